// File: rtl/jtframe_credits_seq_pkg.sv
// Shared types and constants for the credits overlay sequencer.
// Optional build macro: JTFRAME_CREDITS_TIMEOUT_EN (auto-hide timer).
package jtframe_credits_pkg;

  localparam int FRAME_W = 16;
  localparam int PAGE_W  = 4;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SHOW   = 2'd1,
    HIDDEN = 2'd2
  } state_t;

  // Saturating increment: frame counters stick at all-ones instead of wrapping.
  function automatic logic [FRAME_W-1:0] sat_inc(input logic [FRAME_W-1:0] v);
    return (&v) ? v : v + FRAME_W'(1);
  endfunction

endpackage

// File: rtl/jtframe_credits_seq_if.sv
// Signal bundle between the pause/OSD logic and the credits sequencer.
// master drives the video/user inputs; slave is the sequencer itself.
interface jtframe_credits_seq_if;
  import jtframe_credits_pkg::*;

  logic              pxl_cen;
  logic              VB;
  logic              pause;
  logic              btn;
  logic              credits_en;
  logic              enable;
  logic              toggle;
  logic [PAGE_W-1:0] page;
  logic              frame_tick;

  modport master (
    output pxl_cen, VB, pause, btn, credits_en,
    input  enable, toggle, page, frame_tick
  );

  modport slave (
    input  pxl_cen, VB, pause, btn, credits_en,
    output enable, toggle, page, frame_tick
  );
endinterface

// File: rtl/jtframe_credits_seq_deb.sv
// Button conditioner: 2-FF synchroniser followed by a once-per-frame
// debouncer. Emits a one-clk press pulse when the sampled history turns
// all-ones after the button was last seen low.
module jtframe_credits_deb #(
  parameter int DEBW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic frame_tick,
  output logic press
);

  logic [1:0]      sync_q, sync_d;
  logic [DEBW-1:0] hist_q, hist_d;
  logic            stable_q, stable_d;
  logic            press_q, press_d;

  // Next-state for synchroniser, history and armed/stable flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    sync_d   = {sync_q[0], btn};
    hist_d   = hist_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (frame_tick) begin
      hist_d = (hist_q << 1) | DEBW'(sync_q[1]);
      if (!sync_q[1]) begin
        stable_d = 1'b0;
      end else if ((&hist_d) && !stable_q) begin
        press_d  = 1'b1;
        stable_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sync_q   <= '0;
      hist_q   <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/jtframe_credits_seq.sv
// Credits overlay sequencer: frame tick extraction, pause edge detection,
// OFF/SHOW/HIDDEN state machine, page rotation and optional auto-hide.
// Optional build macro: JTFRAME_CREDITS_TIMEOUT_EN enables the TIMEOUT
// auto-hide; without it SHOW is left only by a press or the OFF conditions.
module jtframe_credits_seq
  import jtframe_credits_pkg::*;
#(
  parameter logic               BLKPOL      = 1'b1,
  parameter int                 PAGES       = 1,
  parameter logic [FRAME_W-1:0] PAGE_FRAMES = 16'd600,
  parameter logic [FRAME_W-1:0] TIMEOUT     = 16'd1800,
  parameter int                 DEBW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  jtframe_credits_seq_if.slave bus
);

  localparam logic [PAGE_W-1:0]  LAST_PAGE = PAGE_W'(PAGES - 1);
  localparam logic [FRAME_W-1:0] PAGE_CMP  = PAGE_FRAMES - FRAME_W'(1);

  logic vb;
  logic last_vb_q, last_vb_d;
  logic frame_tick_q, frame_tick_d;
  logic pause_q, pause_d;
  logic pause_rise, pause_fall;
  logic press;
  logic timeout_evt;

  state_t             state_q, state_d;
  logic               enable_q, enable_d;
  logic               toggle_q, toggle_d;
  logic [PAGE_W-1:0]  page_q, page_d;
  logic [FRAME_W-1:0] ptmr_q, ptmr_d;

  assign vb         = BLKPOL ? bus.VB : ~bus.VB;
  assign pause_rise = bus.pause & ~pause_q;
  assign pause_fall = ~bus.pause & pause_q;

  jtframe_credits_deb #(.DEBW(DEBW)) u_deb (
    .clk        (clk),
    .rst        (rst),
    .btn        (bus.btn),
    .frame_tick (frame_tick_q),
    .press      (press)
  );

  // Frame tick on the pixel-enabled blanking rise; pause history every clk.
  always_comb begin
    last_vb_d    = bus.pxl_cen ? vb : last_vb_q;
    frame_tick_d = bus.pxl_cen & vb & ~last_vb_q;
    pause_d      = bus.pause;
  end

  // Edge-detector registers. pause_q resets high so a pause level already
  // present at reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vb_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      pause_q      <= 1'b1;
    end else begin
      last_vb_q    <= last_vb_d;
      frame_tick_q <= frame_tick_d;
      pause_q      <= pause_d;
    end
  end

`ifdef JTFRAME_CREDITS_TIMEOUT_EN
  localparam logic [FRAME_W-1:0] TIMEOUT_CMP = TIMEOUT - FRAME_W'(1);

  logic [FRAME_W-1:0] ttmr_q, ttmr_d;
  logic               show_entry;

  // Timeout counter: clears on any entry into SHOW, counts frames in SHOW.
  always_comb begin
    show_entry  = (state_q == OFF    && pause_rise && bus.credits_en) ||
                  (state_q == HIDDEN && press);
    timeout_evt = (state_q == SHOW) && frame_tick_q && (ttmr_q == TIMEOUT_CMP);
    ttmr_d      = ttmr_q;
    if (show_entry) begin
      ttmr_d = '0;
    end else if (state_q == SHOW && frame_tick_q && ttmr_q != TIMEOUT_CMP) begin
      ttmr_d = sat_inc(ttmr_q);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) ttmr_q <= '0;
    else     ttmr_q <= ttmr_d;
  end
`else
  // No auto-hide in this build; the comparison folds to constant zero and
  // only keeps the parameter list identical between builds.
  assign timeout_evt = 1'b0 && (TIMEOUT != '0);
`endif

  // Sequencer next state, page rotation and registered outputs.
  always_comb begin
    state_d  = state_q;
    toggle_d = 1'b0;
    page_d   = page_q;
    ptmr_d   = ptmr_q;

    case (state_q)
      OFF: begin
        if (pause_rise && bus.credits_en) begin
          state_d = SHOW;
          page_d  = '0;
          ptmr_d  = '0;
        end
      end
      SHOW: begin
        if (frame_tick_q) begin
          if (ptmr_q == PAGE_CMP) begin
            ptmr_d = '0;
            page_d = (page_q >= LAST_PAGE) ? '0 : page_q + PAGE_W'(1);
          end else begin
            ptmr_d = sat_inc(ptmr_q);
          end
        end
        if (press || timeout_evt) begin
          state_d  = HIDDEN;
          toggle_d = 1'b1;
        end
      end
      HIDDEN: begin
        if (press) begin
          state_d  = SHOW;
          toggle_d = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    // Leaving the overlay wins over any press or timeout in the same cycle.
    if (pause_fall || !bus.credits_en) begin
      state_d  = OFF;
      toggle_d = 1'b0;
    end

    enable_d = (state_d != OFF);
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OFF;
      enable_q <= 1'b0;
      toggle_q <= 1'b0;
      page_q   <= '0;
      ptmr_q   <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      toggle_q <= toggle_d;
      page_q   <= page_d;
      ptmr_q   <= ptmr_d;
    end
  end

  assign bus.enable     = enable_q;
  assign bus.toggle     = toggle_q;
  assign bus.page       = page_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_jtframe_credits_seq.sv
// Directed bench for jtframe_credits_seq: PAGES=3, PAGE_FRAMES=4,
// TIMEOUT=20, DEBW=2. Expected toggle events are queued when the stimulus
// that should cause them is driven and popped by the output monitor.
module tb_jtframe_credits_seq;

  typedef struct {
    logic [3:0] page;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   checks   = 0;
  int   failures = 0;
  int   tog_cnt  = 0;
  int   tick_cnt = 0;
  logic tog_prev = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  jtframe_credits_seq_if bus ();

  jtframe_credits_seq #(
    .BLKPOL      (1'b1),
    .PAGES       (3),
    .PAGE_FRAMES (16'd4),
    .TIMEOUT     (16'd20),
    .DEBW        (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One video frame: blanking inactive then active.
  task automatic frame();
    bus.VB = 1'b0;
    cyc(8);
    bus.VB = 1'b1;
    cyc(6);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic push_exp(input logic [3:0] page, input string tag);
    exp_t e;
    e.page = page;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Pixel clock enable at half rate.
  initial begin
    bus.pxl_cen = 1'b0;
    forever begin
      @(negedge clk);
      bus.pxl_cen = ~bus.pxl_cen;
    end
  end

  // Output monitor: toggle width, scoreboard pop, frame tick count.
  always @(negedge clk) begin
    if (bus.toggle === 1'b1) begin
      tog_cnt++;
      check("toggle_width", int'(tog_prev), 0);
      check("toggle_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check({"page_at_", mon_e.tag}, int'(bus.page), int'(mon_e.page));
        check({"enable_at_", mon_e.tag}, int'(bus.enable), 1);
      end
    end
    tog_prev = bus.toggle;
    if (bus.frame_tick === 1'b1) tick_cnt++;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int k0;
    bit found;

    bus.VB         = 1'b0;
    bus.pause      = 1'b0;
    bus.btn        = 1'b0;
    bus.credits_en = 1'b1;

    // 1: reset values, then pause rise enters SHOW one clk later.
    cyc(3);
    check("rst_enable", int'(bus.enable), 0);
    check("rst_toggle", int'(bus.toggle), 0);
    check("rst_page", int'(bus.page), 0);
    check("rst_frame_tick", int'(bus.frame_tick), 0);
    rst = 1'b0;
    frames(2);
    check("off_enable", int'(bus.enable), 0);
    bus.pause = 1'b1;
    cyc(1);
    check("show_enable", int'(bus.enable), 1);
    check("show_page", int'(bus.page), 0);
    frames(1);
    check("show_no_toggle", tog_cnt, 0);

    // 2: two debounced presses -> hide then show, one pulse each.
    push_exp(4'd0, "hide1");
    bus.btn = 1'b1;
    frames(3);
    bus.btn = 1'b0;
    frames(2);
    check("hide1_count", tog_cnt, 1);
    check("hide1_enable", int'(bus.enable), 1);
    push_exp(4'd0, "show2");
    bus.btn = 1'b1;
    frames(3);
    bus.btn = 1'b0;
    frames(2);
    check("show2_count", tog_cnt, 2);
    bus.pause = 1'b0;
    cyc(1);
    check("fall_enable", int'(bus.enable), 0);
    frames(1);
    check("fall_no_toggle", tog_cnt, 2);

    // 3: page rotation 0,1,2,0 at frames 4/8/12, held while HIDDEN.
    bus.pause = 1'b1;
    cyc(1);
    check("reentry_page", int'(bus.page), 0);
    k0 = tick_cnt;
    for (int f = 1; f <= 13; f++) begin
      frame();
      if (f == 3 || f == 4 || f == 8 || f == 12 || f == 13)
        check($sformatf("page_f%0d", f), int'(bus.page), (f / 4) % 3);
    end
    check("tick_count", tick_cnt - k0, 13);
    push_exp(4'd0, "hide3");
    bus.btn = 1'b1;
    frames(2);
    bus.btn = 1'b0;
    frames(6);
    check("hide3_count", tog_cnt, 3);
    check("hidden_page_hold", int'(bus.page), 0);

    // 4: auto-hide after TIMEOUT frames (only with the timeout build).
    bus.pause = 1'b0;
    cyc(2);
    bus.pause = 1'b1;
    cyc(1);
    t0 = tog_cnt;
`ifdef JTFRAME_CREDITS_TIMEOUT_EN
    push_exp(4'd2, "timeout");
    frames(19);
    check("timeout_early", tog_cnt - t0, 0);
    frames(1);
    check("timeout_fire", tog_cnt - t0, 1);
    check("timeout_enable", int'(bus.enable), 1);
`else
    frames(50);
    check("no_timeout", tog_cnt - t0, 0);
    check("no_timeout_enable", int'(bus.enable), 1);
`endif

    // 5: press and pause fall land on the same clk -> OFF, no toggle.
    bus.pause = 1'b0;
    cyc(2);
    bus.pause = 1'b1;
    cyc(1);
    t0 = tog_cnt;
    bus.btn = 1'b1;
    frames(1);
    bus.VB = 1'b0;
    cyc(8);
    bus.VB = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) found = 1'b1;
    end
    check("tick_wait", int'(found), 1);
    cyc(1);
    bus.pause = 1'b0;
    cyc(1);
    check("prio_enable", int'(bus.enable), 0);
    cyc(3);
    bus.btn = 1'b0;
    frames(2);
    check("prio_no_toggle", tog_cnt - t0, 0);

    // 6: reset while HIDDEN with pause held high.
    bus.pause = 1'b1;
    cyc(1);
    check("s6_enable", int'(bus.enable), 1);
    frames(2);
    push_exp(4'd1, "hide6");
    bus.btn = 1'b1;
    frames(2);
    bus.btn = 1'b0;
    frames(1);
    check("s6_hidden_page", int'(bus.page), 1);
    check("s6_hidden_enable", int'(bus.enable), 1);
    t0 = tog_cnt;
    rst = 1'b1;
    cyc(1);
    check("mid_rst_enable", int'(bus.enable), 0);
    check("mid_rst_page", int'(bus.page), 0);
    check("mid_rst_toggle", int'(bus.toggle), 0);
    cyc(1);
    rst = 1'b0;
    frames(3);
    check("post_rst_enable", int'(bus.enable), 0);
    check("post_rst_no_toggle", tog_cnt - t0, 0);
    bus.pause = 1'b0;
    cyc(2);
    bus.pause = 1'b1;
    cyc(1);
    check("fresh_edge_enable", int'(bus.enable), 1);
    check("fresh_edge_page", int'(bus.page), 0);

    cyc(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
